// File: rtl/oled_cmd_scheduler.sv
// Two-requester command scheduler for an OLED controller: issues the power-on command,
// then round-robins requests. Build macro OLED_AUTO_REFRESH_EN adds a periodic refresh.
module oled_cmd_scheduler #(
    parameter int N_COLOR_BITS  = 8,
    parameter int ACK_TIMEOUT   = 64,
    parameter int REFRESH_TICKS = 600000
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic [1:0]              i_REQ,
    input  logic [1:0]              i_REQ0_MODE,
    input  logic [1:0]              i_REQ1_MODE,
    input  logic [N_COLOR_BITS-1:0] i_REQ0_COLOR,
    input  logic [N_COLOR_BITS-1:0] i_REQ1_COLOR,
    input  logic                    i_READY,
    output logic [1:0]              o_MODE,
    output logic [N_COLOR_BITS-1:0] o_BACKGROUND_COLOR,
    output logic                    o_START,
    output logic [1:0]              o_GNT,
    output logic [1:0]              o_DONE,
    output logic                    o_ERR,
    output logic                    o_INIT_DONE
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_BUSY
    } state_t;

    state_t                  state_reg;
    logic [ACK_W-1:0]        ack_cnt_reg;
    logic                    rr_prio_reg;   // requester that wins when both request
    logic                    init_cmd_reg;  // command in flight is the power-on command
    logic [1:0]              mode_reg;
    logic [N_COLOR_BITS-1:0] color_reg;
    logic                    start_reg;
    logic [1:0]              gnt_reg;
    logic [1:0]              done_reg;
    logic                    err_reg;
    logic                    init_done_reg;

    logic [1:0]              req_mode  [2];
    logic [N_COLOR_BITS-1:0] req_color [2];
    logic                    pick_valid;
    logic                    pick_id;
    logic [1:0]              pick_onehot;

    assign req_mode[0]  = i_REQ0_MODE;
    assign req_mode[1]  = i_REQ1_MODE;
    assign req_color[0] = i_REQ0_COLOR;
    assign req_color[1] = i_REQ1_COLOR;

    always_comb begin
        pick_valid = |i_REQ;
        pick_id    = (i_REQ == 2'b11) ? rr_prio_reg : i_REQ[1];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_onehot
            assign pick_onehot[gi] = pick_valid && (pick_id == 1'(gi));
        end
    endgenerate

`ifdef OLED_AUTO_REFRESH_EN
    localparam int REF_W = $clog2(REFRESH_TICKS + 1);

    logic [REF_W-1:0]        ref_cnt_reg;
    logic                    ref_pend_reg;
    logic                    ref_cmd_reg;
    logic [1:0]              last_mode_reg;
    logic [N_COLOR_BITS-1:0] last_color_reg;
    logic                    ref_tick;

    assign ref_tick = init_done_reg && (ref_cnt_reg == REF_W'(REFRESH_TICKS - 1));

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            ref_cnt_reg <= '0;
        end else if (!init_done_reg || ref_tick) begin
            ref_cnt_reg <= '0;
        end else begin
            ref_cnt_reg <= ref_cnt_reg + 1'b1;
        end
    end
`endif

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_reg     <= S_INIT;
            ack_cnt_reg   <= '0;
            rr_prio_reg   <= 1'b0;
            init_cmd_reg  <= 1'b0;
            mode_reg      <= 2'b00;
            color_reg     <= '0;
            start_reg     <= 1'b0;
            gnt_reg       <= 2'b00;
            done_reg      <= 2'b00;
            err_reg       <= 1'b0;
            init_done_reg <= 1'b0;
`ifdef OLED_AUTO_REFRESH_EN
            ref_pend_reg   <= 1'b0;
            ref_cmd_reg    <= 1'b0;
            last_mode_reg  <= 2'b01;
            last_color_reg <= '0;
`endif
        end else begin
            start_reg <= 1'b0;
            done_reg  <= 2'b00;
            err_reg   <= 1'b0;
            case (state_reg)
                S_INIT: begin
                    if (i_READY) begin
                        mode_reg     <= 2'b00;
                        color_reg    <= '0;
                        gnt_reg      <= 2'b00;
                        start_reg    <= 1'b1;
                        init_cmd_reg <= 1'b1;
                        ack_cnt_reg  <= '0;
                        state_reg    <= S_ACK;
                    end
                end
                S_IDLE: begin
                    if (pick_valid) begin
                        mode_reg    <= req_mode[pick_id];
                        color_reg   <= req_color[pick_id];
                        gnt_reg     <= pick_onehot;
                        rr_prio_reg <= ~pick_id;
                        state_reg   <= S_ISSUE;
                    end
`ifdef OLED_AUTO_REFRESH_EN
                    else if (ref_pend_reg) begin
                        mode_reg    <= last_mode_reg;
                        color_reg   <= last_color_reg;
                        ref_cmd_reg <= 1'b1;
                        state_reg   <= S_ISSUE;
                    end
`endif
                end
                S_ISSUE: begin
                    start_reg   <= 1'b1;
                    ack_cnt_reg <= '0;
                    state_reg   <= S_ACK;
                end
                S_ACK: begin
                    if (!i_READY) begin
                        state_reg <= S_BUSY;
                    end else if (ack_cnt_reg == ACK_W'(ACK_TIMEOUT - 1)) begin
                        // Interface never acknowledged: abandon; the power-on command is retried.
                        err_reg   <= 1'b1;
                        gnt_reg   <= 2'b00;
                        state_reg <= init_cmd_reg ? S_INIT : S_IDLE;
`ifdef OLED_AUTO_REFRESH_EN
                        ref_cmd_reg <= 1'b0;
`endif
                    end else begin
                        ack_cnt_reg <= ack_cnt_reg + 1'b1;
                    end
                end
                S_BUSY: begin
                    if (i_READY) begin
                        if (init_cmd_reg) begin
                            init_done_reg <= 1'b1;
                            init_cmd_reg  <= 1'b0;
                        end else begin
                            done_reg <= gnt_reg;
                        end
`ifdef OLED_AUTO_REFRESH_EN
                        if (ref_cmd_reg) begin
                            ref_cmd_reg  <= 1'b0;
                            ref_pend_reg <= 1'b0;
                        end else if (!init_cmd_reg) begin
                            last_mode_reg  <= mode_reg;
                            last_color_reg <= color_reg;
                        end
`endif
                        gnt_reg   <= 2'b00;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_INIT;
            endcase
`ifdef OLED_AUTO_REFRESH_EN
            // A new period wins over a same-cycle completion; repeats while pending merge.
            if (ref_tick) begin
                ref_pend_reg <= 1'b1;
            end
`endif
        end
    end

    assign o_MODE             = mode_reg;
    assign o_BACKGROUND_COLOR = color_reg;
    assign o_START            = start_reg;
    assign o_GNT              = gnt_reg;
    assign o_DONE             = done_reg;
    assign o_ERR              = err_reg;
    assign o_INIT_DONE        = init_done_reg;

endmodule
